// File: rtl/id_if.sv
// Decode-stage bus: fetch/hazard/write-back inputs and the ID/EX register outputs.
// The slave modport is the decode stage's view; master is the driver's view.
interface id_if;
  logic        freeze;
  logic        flush;
  logic [31:0] pc_in;
  logic [31:0] instruction;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;

  logic [31:0] pc_out;
  logic [3:0]  exe_cmd;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en_out;
  logic [1:0]  br_type;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] reg2;
  logic [4:0]  dest;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        two_src;

  modport slave (
    input  freeze, flush, pc_in, instruction, wb_en, wb_dest, wb_value,
    output pc_out, exe_cmd, mem_r_en, mem_w_en, wb_en_out, br_type,
           val1, val2, reg2, dest, src1, src2, two_src
  );

  modport master (
    output freeze, flush, pc_in, instruction, wb_en, wb_dest, wb_value,
    input  pc_out, exe_cmd, mem_r_en, mem_w_en, wb_en_out, br_type,
           val1, val2, reg2, dest, src1, src2, two_src
  );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: opcode decode, 2R/1W register file with write-back bypass,
// immediate sign extension and the ID/EX pipeline register.
module id_stage #(
  parameter int REG_COUNT = 32
) (
  input logic clk,
  input logic rst,
  id_if.slave bus
);
  localparam int DATA_W = 32;

  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign opcode = bus.instruction[31:26];
  assign rs     = bus.instruction[25:21];
  assign rt     = bus.instruction[20:16];
  assign rd     = bus.instruction[15:11];
  assign imm    = bus.instruction[15:0];

  logic [DATA_W-1:0] rf [REG_COUNT];
  logic              wb_live;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign wb_live = bus.wb_en && (bus.wb_dest != 5'd0);

  // r0 always reads zero; a write landing this cycle is forwarded to the reader
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) rs_val = (wb_live && bus.wb_dest == rs) ? bus.wb_value : rf[rs];
    if (rt != 5'd0) rt_val = (wb_live && bus.wb_dest == rt) ? bus.wb_value : rf[rt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (wb_live) begin
      rf[bus.wb_dest] <= bus.wb_value;
    end
  end

  logic [3:0]        cmd_d;
  logic              mr_d, mw_d, wb_d, rtype_d;
  logic [1:0]        br_d;
  logic [4:0]        dest_d;
  logic [DATA_W-1:0] val2_d;

  always_comb begin
    cmd_d   = 4'b0000;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    wb_d    = 1'b0;
    rtype_d = 1'b0;
    br_d    = 2'd0;
    case (opcode)
      6'b000001: begin rtype_d = 1'b1; cmd_d = 4'b0000; end
      6'b000011: begin rtype_d = 1'b1; cmd_d = 4'b0010; end
      6'b000101: begin rtype_d = 1'b1; cmd_d = 4'b0100; end
      6'b000110: begin rtype_d = 1'b1; cmd_d = 4'b0101; end
      6'b000111: begin rtype_d = 1'b1; cmd_d = 4'b0110; end
      6'b001000: begin rtype_d = 1'b1; cmd_d = 4'b0111; end
      6'b001001: begin rtype_d = 1'b1; cmd_d = 4'b1000; end
      6'b001010: begin rtype_d = 1'b1; cmd_d = 4'b1000; end
      6'b001011: begin rtype_d = 1'b1; cmd_d = 4'b1001; end
      6'b001100: begin rtype_d = 1'b1; cmd_d = 4'b1010; end
      6'b100000: begin wb_d = 1'b1; cmd_d = 4'b0000; end
      6'b100001: begin wb_d = 1'b1; cmd_d = 4'b0010; end
      6'b100100: begin wb_d = 1'b1; mr_d = 1'b1; end
      6'b100101: mw_d = 1'b1;
      6'b101000: br_d = 2'd1;
      6'b101001: br_d = 2'd2;
      6'b101010: br_d = 2'd3;
      default: ;
    endcase
    if (rtype_d) wb_d = 1'b1;
    dest_d = rtype_d ? rd : (wb_d ? rt : 5'd0);
    val2_d = rtype_d ? rt_val : DATA_W'(sext16(imm));
  end

  assign bus.src1    = rs;
  assign bus.src2    = rt;
  assign bus.two_src = rtype_d || mw_d || (br_d == 2'd2);

  logic [DATA_W-1:0] pc_p1, val1_p1, val2_p1, reg2_p1;
  logic [3:0]        cmd_p1;
  logic              mr_p1, mw_p1, wb_p1;
  logic [1:0]        br_p1;
  logic [4:0]        dest_p1;

  // ID/EX boundary: reset, flush and freeze all load a full zero bubble
  always_ff @(posedge clk) begin
    if (rst || bus.flush || bus.freeze) begin
      pc_p1   <= '0;
      cmd_p1  <= '0;
      mr_p1   <= 1'b0;
      mw_p1   <= 1'b0;
      wb_p1   <= 1'b0;
      br_p1   <= '0;
      val1_p1 <= '0;
      val2_p1 <= '0;
      reg2_p1 <= '0;
      dest_p1 <= '0;
    end else begin
      pc_p1   <= bus.pc_in;
      cmd_p1  <= cmd_d;
      mr_p1   <= mr_d;
      mw_p1   <= mw_d;
      wb_p1   <= wb_d;
      br_p1   <= br_d;
      val1_p1 <= rs_val;
      val2_p1 <= val2_d;
      reg2_p1 <= rt_val;
      dest_p1 <= dest_d;
    end
  end

  assign bus.pc_out    = pc_p1;
  assign bus.exe_cmd   = cmd_p1;
  assign bus.mem_r_en  = mr_p1;
  assign bus.mem_w_en  = mw_p1;
  assign bus.wb_en_out = wb_p1;
  assign bus.br_type   = br_p1;
  assign bus.val1      = val1_p1;
  assign bus.val2      = val2_p1;
  assign bus.reg2      = reg2_p1;
  assign bus.dest      = dest_p1;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver predicts each ID/EX result from an
// opcode table and a register-file array; a monitor compares after every edge.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_if bus();
  id_stage #(.REG_COUNT(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        mr, mw, wb;
    logic [1:0]  br;
    logic [31:0] v1, v2, r2;
    logic [4:0]  dest;
    bit          ctl_only;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mrf [32];
  int          checks = 0;
  int          passed = 0;

  localparam logic [5:0] OPS [17] = '{6'b000001, 6'b000011, 6'b000101, 6'b000110,
    6'b000111, 6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b100000,
    6'b100001, 6'b100100, 6'b100101, 6'b101000, 6'b101001, 6'b101010};

  function automatic logic [31:0] sx(input logic [15:0] imm);
    int v;
    v = int'(imm);
    if (v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  // Instruction table: ALU command, memory/branch/write-back controls per opcode
  function automatic void mdec(input logic [5:0] op, output logic [3:0] cmd,
                               output logic mr, output logic mw, output logic wb,
                               output logic [1:0] br, output bit rtype, output bit legal);
    cmd = 4'd0; mr = 0; mw = 0; wb = 0; br = 2'd0; rtype = 0; legal = 1;
    case (op)
      6'b000001: begin rtype = 1; cmd = 4'd0;  end
      6'b000011: begin rtype = 1; cmd = 4'd2;  end
      6'b000101: begin rtype = 1; cmd = 4'd4;  end
      6'b000110: begin rtype = 1; cmd = 4'd5;  end
      6'b000111: begin rtype = 1; cmd = 4'd6;  end
      6'b001000: begin rtype = 1; cmd = 4'd7;  end
      6'b001001: begin rtype = 1; cmd = 4'd8;  end
      6'b001010: begin rtype = 1; cmd = 4'd8;  end
      6'b001011: begin rtype = 1; cmd = 4'd9;  end
      6'b001100: begin rtype = 1; cmd = 4'd10; end
      6'b100000: begin wb = 1; cmd = 4'd0; end
      6'b100001: begin wb = 1; cmd = 4'd2; end
      6'b100100: begin wb = 1; mr = 1; end
      6'b100101: mw = 1;
      6'b101000: br = 2'd1;
      6'b101001: br = 2'd2;
      6'b101010: br = 2'd3;
      default: legal = 0;
    endcase
    if (rtype) wb = 1;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input bit we,
                                        input logic [4:0] wd, input logic [31:0] wv);
    if (a == 5'd0) return 32'd0;
    if (we && wd == a) return wv;
    return mrf[a];
  endfunction

  task automatic step(input bit r, input bit fz, input bit fl, input logic [31:0] pc,
                      input logic [31:0] ins, input bit we, input logic [4:0] wd,
                      input logic [31:0] wv);
    exp_t        e;
    logic [5:0]  op;
    logic [4:0]  a, b, d;
    logic [3:0]  cmd;
    logic        mr, mw, wb;
    logic [1:0]  br;
    bit          rtype, legal, two;
    @(negedge clk);
    rst = r; bus.freeze = fz; bus.flush = fl; bus.pc_in = pc; bus.instruction = ins;
    bus.wb_en = we; bus.wb_dest = wd; bus.wb_value = wv;
    #1;
    op = ins[31:26]; a = ins[25:21]; b = ins[20:16]; d = ins[15:11];
    mdec(op, cmd, mr, mw, wb, br, rtype, legal);
    two = rtype || op == 6'b100101 || op == 6'b101001;
    checks++;
    if (bus.src1 == a && bus.src2 == b && bus.two_src == two) passed++;
    else $display("FAIL hazard ins=%h got src1=%0d src2=%0d two=%0d exp src1=%0d src2=%0d two=%0d",
                  ins, bus.src1, bus.src2, bus.two_src, a, b, two);
    e = '{pc: 32'd0, cmd: 4'd0, mr: 1'b0, mw: 1'b0, wb: 1'b0, br: 2'd0,
          v1: 32'd0, v2: 32'd0, r2: 32'd0, dest: 5'd0, ctl_only: 1'b0};
    if (!(r || fz || fl)) begin
      if (!legal) e.ctl_only = 1'b1;
      else begin
        e.pc = pc; e.cmd = cmd; e.mr = mr; e.mw = mw; e.wb = wb; e.br = br;
        e.v1 = mread(a, we, wd, wv);
        e.r2 = mread(b, we, wd, wv);
        e.v2 = rtype ? e.r2 : sx(ins[15:0]);
        e.dest = rtype ? d : (wb ? b : 5'd0);
      end
    end
    q.push_back(e);
    @(posedge clk);
    if (r) for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    else if (we && wd != 5'd0) mrf[wd] = wv;
  endtask

  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        ok = bus.exe_cmd == e.cmd && bus.mem_r_en == e.mr && bus.mem_w_en == e.mw &&
             bus.wb_en_out == e.wb && bus.br_type == e.br && bus.dest == e.dest;
        if (!e.ctl_only)
          ok = ok && bus.pc_out == e.pc && bus.val1 == e.v1 && bus.val2 == e.v2 &&
               bus.reg2 == e.r2;
        checks++;
        if (ok) passed++;
        else $display("FAIL idex t=%0t got pc=%h cmd=%h mr=%b mw=%b wb=%b br=%0d v1=%h v2=%h r2=%h dest=%0d exp pc=%h cmd=%h mr=%b mw=%b wb=%b br=%0d v1=%h v2=%h r2=%h dest=%0d ctl_only=%0d",
                      $time, bus.pc_out, bus.exe_cmd, bus.mem_r_en, bus.mem_w_en, bus.wb_en_out,
                      bus.br_type, bus.val1, bus.val2, bus.reg2, bus.dest, e.pc, e.cmd, e.mr,
                      e.mw, e.wb, e.br, e.v1, e.v2, e.r2, e.dest, e.ctl_only);
      end
    end
  end

  initial begin : driver
    logic [31:0] ins, val;
    logic [5:0]  op;
    bit          fz, fl, r, we;
    rst = 1'b1; bus.freeze = 0; bus.flush = 0; bus.pc_in = 0; bus.instruction = 0;
    bus.wb_en = 0; bus.wb_dest = 0; bus.wb_value = 0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;

    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 32'h4, enc(6'b000001, 5'd5, 5'd0, {5'd1, 11'd0}), 0, 0, 0);
    step(0, 0, 0, 32'h8, 32'h0, 1, 5'd1, 32'd1546);
    step(0, 0, 0, 32'hC, 32'h04011000, 0, 0, 0);
    step(0, 0, 0, 32'h10, enc(6'b100001, 5'd3, 5'd5, 16'h1A34), 1, 5'd3, 32'hFFFFF9F6);
    step(0, 0, 0, 32'h14, 32'h0, 1, 5'd8, 32'd1028);
    step(0, 0, 0, 32'h18, 32'h0, 1, 5'd5, 32'd7);
    step(0, 0, 0, 32'h1C, 32'h9505FFFC, 0, 0, 0);
    ins = enc(6'b101001, 5'd1, 5'd3, 16'hFFF1);
    step(0, 0, 1, 32'h20, ins, 0, 0, 0);
    step(0, 1, 0, 32'h20, ins, 0, 0, 0);
    step(0, 1, 1, 32'h20, ins, 1, 5'd9, 32'd99);
    step(0, 0, 0, 32'h20, ins, 0, 0, 0);
    step(0, 0, 0, 32'h24, enc(6'b000001, 5'd0, 5'd0, {5'd1, 11'd0}), 1, 5'd0, 32'hDEADBEEF);
    step(0, 0, 0, 32'h28, enc(6'b000001, 5'd0, 5'd9, {5'd1, 11'd0}), 0, 0, 0);
    step(0, 0, 0, 32'h2C, {6'b111111, 26'h2A5A5A5}, 0, 0, 0);
    step(0, 0, 0, 32'h30, 32'h0, 1, 5'd4, 32'd55);
    step(1, 1, 1, 32'h34, enc(6'b100000, 5'd4, 5'd6, 16'h0010), 1, 5'd4, 32'd77);
    step(0, 0, 0, 32'h38, enc(6'b100000, 5'd4, 5'd6, 16'h8000), 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      op = ($urandom_range(0, 99) < 85) ? OPS[$urandom_range(0, 16)] : 6'($urandom);
      ins = {op, 26'($urandom)};
      r  = ($urandom_range(0, 99) < 2);
      fz = ($urandom_range(0, 99) < 8);
      fl = ($urandom_range(0, 99) < 8);
      we = ($urandom_range(0, 99) < 60);
      val = $urandom;
      step(r, fz, fl, $urandom, ins, we, 5'($urandom), val);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain got %0d pending exp 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
